// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP issue controller.
// Op codes, FSM states, rounding-mode and flag encodings.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ARITH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } fpu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_RESP = 2'd3
  } fpu_state_t;

  localparam logic [2:0] RM_DYN = 3'b111;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  // Encodings 5..7 are reserved once dynamic rm is resolved
  function automatic logic rm_illegal(
    input logic [2:0] rm
  );
    return rm >= 3'd5;
  endfunction

endpackage

// File: rtl/fpu_regfile.sv
// FP register file: two async read ports, one sync write port.
// Every register, including index 0, is writable.
module fpu_regfile #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: decodes load/store/arith, drives the
// datapath handshake, writes back results and owns frm/fflags.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NREGS       = 32,
  parameter int TIMEOUT_CYC = 64,
  localparam int REG_AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  fpu_op_t           req_op,
  input  logic [6:0]        req_funct7,
  input  logic [2:0]        req_rm,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [DATA_W-1:0] req_load_data,
  output logic              resp_valid,
  output logic              resp_illegal,
  output logic              resp_timeout,
  output logic [DATA_W-1:0] resp_store_data,
  output logic              exu_start,
  output logic [DATA_W-1:0] exu_a,
  output logic [DATA_W-1:0] exu_b,
  output logic [6:0]        exu_funct7,
  output logic [2:0]        exu_rm,
  input  logic              exu_done,
  input  logic [DATA_W-1:0] exu_result,
  input  logic [4:0]        exu_flags,
  input  logic              csr_frm_we,
  input  logic [2:0]        csr_frm_wdata,
  input  logic              csr_fflags_we,
  input  logic [4:0]        csr_fflags_wdata,
  output logic [2:0]        frm,
  output logic [4:0]        fflags
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  fpu_state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic              illegal_q;
  logic              timeout_q;
  logic [REG_AW-1:0] rd_q;

  logic              accept;
  logic [2:0]        rm_res;
  logic              ld_acc;
  logic              st_acc;
  logic              ar_ok;
  logic              bad_acc;
  logic              in_exec;
  logic              cnt_last;
  logic              to_hit;
  logic [4:0]        fflags_d;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  always_comb begin
    accept   = req_valid && (state_q == S_IDLE);
    rm_res   = (req_rm == RM_DYN) ? frm : req_rm;
    ld_acc   = accept && (req_op == OP_LOAD);
    st_acc   = accept && (req_op == OP_STORE);
    ar_ok    = accept && (req_op == OP_ARITH)
               && !rm_illegal(rm_res);
    // Bad rm or an undefined op code both answer as illegal
    bad_acc  = accept && !ld_acc && !st_acc && !ar_ok;
    in_exec  = (state_q == S_EXEC);
    cnt_last = (cnt_q == CW'(TIMEOUT_CYC - 1));
    to_hit   = in_exec && !exu_done && cnt_last;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          !accept: state_d = S_IDLE;
          ar_ok:   state_d = S_EXEC;
          default: state_d = S_RESP;
        endcase
      end
      S_EXEC: begin
        if (exu_done) begin
          state_d = S_WB;
        end else if (cnt_last) begin
          state_d = S_RESP;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fflags_d = csr_fflags_we ? csr_fflags_wdata : fflags;
    if (state_q == S_WB) begin
      fflags_d = fflags_d | exu_flags;
    end
  end

  always_comb begin
    rf_we    = ld_acc || (state_q == S_WB);
    rf_waddr = req_rd;
    rf_wdata = req_load_data;
    if (state_q == S_WB) begin
      rf_waddr = rd_q;
      rf_wdata = exu_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      illegal_q       <= 1'b0;
      timeout_q       <= 1'b0;
      rd_q            <= '0;
      exu_a           <= '0;
      exu_b           <= '0;
      exu_funct7      <= '0;
      exu_rm          <= '0;
      resp_store_data <= '0;
      frm             <= '0;
      fflags          <= '0;
    end else begin
      state_q <= state_d;
      fflags  <= fflags_d;
      if (csr_frm_we) begin
        frm <= csr_frm_wdata;
      end
      if (ar_ok) begin
        exu_a      <= rf_a;
        exu_b      <= rf_b;
        exu_funct7 <= req_funct7;
        exu_rm     <= rm_res;
        rd_q       <= req_rd;
        cnt_q      <= '0;
      end else if (in_exec && !exu_done && !cnt_last) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (st_acc) begin
        resp_store_data <= rf_b;
      end
      if (bad_acc) begin
        illegal_q <= 1'b1;
      end
      if (to_hit) begin
        timeout_q <= 1'b1;
      end
      if (state_q == S_RESP) begin
        illegal_q <= 1'b0;
        timeout_q <= 1'b0;
      end
    end
  end

  // Held low during reset so every output reads 0
  assign req_ready    = !rst && (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP)
                        || (state_q == S_WB);
  assign resp_illegal = (state_q == S_RESP) && illegal_q;
  assign resp_timeout = (state_q == S_RESP) && timeout_q;
  assign exu_start    = in_exec && (cnt_q == '0);

  fpu_regfile #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W),
    .AW     (REG_AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (req_rs1),
    .rdata_a (rf_a),
    .raddr_b (req_rs2),
    .rdata_b (rf_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

endmodule
